// File: rtl/clk_ratio_meter_if.sv
`timescale 1ns/1ps
// clk_ratio_meter_if: measurement control and result bus for clk_ratio_meter.
// The master drives enable, the divided clock and the expected ratio; the slave returns results.
interface clk_ratio_meter_if #(
    parameter int unsigned RATIO_WD = 8
);
    logic                meas_en;
    logic                div_clk;
    logic [RATIO_WD-1:0] exp_ratio;
    logic [RATIO_WD-1:0] ratio;
    logic                ratio_vld;
    logic [RATIO_WD-1:0] high_cnt;
    logic                locked;
    logic                ratio_err;
    logic                mismatch;
    logic                timeout;

    modport master (
        output meas_en, div_clk, exp_ratio,
        input  ratio, ratio_vld, high_cnt, locked, ratio_err, mismatch, timeout
    );

    modport slave (
        input  meas_en, div_clk, exp_ratio,
        output ratio, ratio_vld, high_cnt, locked, ratio_err, mismatch, timeout
    );
endinterface

// File: rtl/clk_ratio_meter.sv
`timescale 1ns/1ps
// clk_ratio_meter: measures a divided clock's period in reference cycles, locks on a stable
// period and flags ratio error, mismatch and stall. Define CLK_RATIO_METER_DUTY_EN to build high_cnt.
module clk_ratio_meter #(
    parameter int unsigned RATIO_WD    = 8,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             ref_clk,
    input  logic             rst,
    clk_ratio_meter_if.slave bus
);
    localparam int unsigned         CONSEC_WD = 4;
    localparam logic [RATIO_WD-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [RATIO_WD-1:0]    per_q;
    logic [RATIO_WD-1:0]    gap_q;
    logic [RATIO_WD-1:0]    ratio_q;
    logic [CONSEC_WD-1:0]   consec_q;
    logic                   ratio_vld_q;
    logic                   locked_q;
    logic                   ratio_err_q;
    logic                   mismatch_q;
    logic                   timeout_q;

    logic                   sync_c;
    logic                   rd;
    logic                   fd;
    logic                   timeout_hit;
    logic                   sample;
    logic                   same;
    logic [RATIO_WD-1:0]    gap_nx;
    logic [CONSEC_WD-1:0]   consec_inc;

    function automatic logic [RATIO_WD-1:0] sat_inc(input logic [RATIO_WD-1:0] v);
        return (v == CNT_MAX) ? v : v + RATIO_WD'(1);
    endfunction

    assign sync_c      = sync_q[SYNC_STAGES-1];
    assign rd          = sync_c & ~prev_q;
    assign fd          = ~sync_c & prev_q;
    // An edge clears the gap counter in its own cycle, so an edge always beats a timeout.
    assign gap_nx      = (rd | fd) ? '0 : sat_inc(gap_q);
    assign timeout_hit = (gap_nx == CNT_MAX);
    assign sample      = bus.meas_en && rd && (state == MEASURE || state == LOCKED);
    assign same        = (per_q == ratio_q);
    assign consec_inc  = same ? consec_q + CONSEC_WD'(1) : CONSEC_WD'(1);

    // Synchronizer plus edge-detect flop on the asynchronous divided clock
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.div_clk};
            prev_q <= sync_c;
        end
    end

    // Measurement FSM with counters and registered outputs
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state       <= IDLE;
            per_q       <= '0;
            gap_q       <= '0;
            ratio_q     <= '0;
            consec_q    <= '0;
            ratio_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            ratio_err_q <= 1'b0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            ratio_vld_q <= 1'b0;
            ratio_err_q <= locked_q && (ratio_q != bus.exp_ratio);
            if (!bus.meas_en) begin
                state      <= IDLE;
                per_q      <= '0;
                gap_q      <= '0;
                ratio_q    <= '0;
                consec_q   <= '0;
                locked_q   <= 1'b0;
                mismatch_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                if (state == IDLE) begin
                    per_q <= '0;
                    gap_q <= '0;
                end else begin
                    per_q <= rd ? RATIO_WD'(1) : sat_inc(per_q);
                    gap_q <= gap_nx;
                end
                unique case (state)
                    IDLE: begin
                        consec_q <= '0;
                        state    <= WAIT_EDGE;
                    end
                    WAIT_EDGE: begin
                        if (rd) begin
                            state <= MEASURE;
                        end else if (timeout_hit) begin
                            timeout_q <= 1'b1;
                            consec_q  <= '0;
                        end
                    end
                    MEASURE: begin
                        if (rd) begin
                            ratio_q     <= per_q;
                            ratio_vld_q <= 1'b1;
                            consec_q    <= consec_inc;
                            if (consec_inc >= CONSEC_WD'(LOCK_CNT)) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (timeout_hit) begin
                            timeout_q <= 1'b1;
                            consec_q  <= '0;
                            state     <= WAIT_EDGE;
                        end
                    end
                    LOCKED: begin
                        if (rd) begin
                            ratio_q     <= per_q;
                            ratio_vld_q <= 1'b1;
                            if (!same) begin
                                mismatch_q <= 1'b1;
                                consec_q   <= CONSEC_WD'(1);
                                locked_q   <= 1'b0;
                                state      <= MEASURE;
                            end
                        end else if (timeout_hit) begin
                            timeout_q <= 1'b1;
                            consec_q  <= '0;
                            locked_q  <= 1'b0;
                            state     <= WAIT_EDGE;
                        end
                    end
                endcase
            end
        end
    end

`ifdef CLK_RATIO_METER_DUTY_EN
    logic [RATIO_WD-1:0] high_q;
    logic [RATIO_WD-1:0] high_cap_q;
    logic [RATIO_WD-1:0] high_cnt_q;

    // High-phase counter, captured on the fall and published with each sample
    always_ff @(posedge ref_clk) begin
        if (rst || !bus.meas_en || state == IDLE) begin
            high_q     <= '0;
            high_cap_q <= '0;
            high_cnt_q <= '0;
        end else begin
            high_q <= rd ? RATIO_WD'(1) : sat_inc(high_q);
            if (fd) begin
                high_cap_q <= high_q;
            end
            if (sample) begin
                high_cnt_q <= high_cap_q;
            end
        end
    end

    assign bus.high_cnt = high_cnt_q;
`else
    assign bus.high_cnt = '0;
`endif

    assign bus.ratio     = ratio_q;
    assign bus.ratio_vld = ratio_vld_q;
    assign bus.locked    = locked_q;
    assign bus.ratio_err = ratio_err_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_clk_ratio_meter.sv
`timescale 1ns/1ps
// tb_clk_ratio_meter: scoreboard bench; expected samples come from rise/fall timestamps of the
// generated divided clock, checked by an independent monitor on every ratio_vld.
module tb_clk_ratio_meter;
    localparam int unsigned RATIO_WD    = 8;
    localparam int unsigned LOCK_CNT    = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned SAT         = (1 << RATIO_WD) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_ratio_meter_if #(.RATIO_WD(RATIO_WD)) bus ();

    clk_ratio_meter #(
        .RATIO_WD   (RATIO_WD),
        .LOCK_CNT   (LOCK_CNT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .ref_clk(clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        int unsigned ratio;
        int unsigned high;
        bit          locked;
        bit          mismatch;
        bit          timeout;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned cyc;
    bit          pend_err;
    bit          err_exp;

    // Reference model state, in terms of observed divided-clock edges
    bit          armed;
    bit          m_locked;
    bit          m_mismatch;
    bit          m_timeout;
    int unsigned m_ratio;
    int unsigned consec;
    int unsigned last_rise;
    int unsigned last_fall;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_restart();
        armed      = 1'b1;
        m_locked   = 1'b0;
        m_mismatch = 1'b0;
        m_timeout  = 1'b0;
        m_ratio    = 0;
        consec     = 0;
    endtask

    task automatic model_timeout();
        m_timeout = 1'b1;
        m_locked  = 1'b0;
        consec    = 0;
        armed     = 1'b1;
    endtask

    task automatic model_rise(input int unsigned c);
        int unsigned s;
        int unsigned h;
        if (armed) begin
            armed = 1'b0;
        end else begin
            s = sat(c - last_rise);
            h = sat(last_fall - last_rise);
`ifndef CLK_RATIO_METER_DUTY_EN
            h = 0;
`endif
            if (m_locked) begin
                if (s != m_ratio) begin
                    m_mismatch = 1'b1;
                    m_locked   = 1'b0;
                    consec     = 1;
                end
            end else begin
                consec = (s == m_ratio) ? consec + 1 : 1;
                if (consec >= LOCK_CNT) m_locked = 1'b1;
            end
            m_ratio = s;
            sb.push_back('{ratio: s, high: h, locked: m_locked, mismatch: m_mismatch, timeout: m_timeout});
        end
        last_rise = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input bit v);
        if (v && !bus.div_clk) model_rise(cyc);
        if (!v && bus.div_clk) last_fall = cyc;
        bus.div_clk = v;
    endtask

    task automatic run_periods(input int unsigned ratio, input int unsigned high, input int unsigned n);
        repeat (n) begin
            set_div(1'b1);
            repeat (high) tick();
            set_div(1'b0);
            repeat (ratio - high) tick();
        end
    endtask

    task automatic restart(input int unsigned exp);
        repeat (4) tick();
        check("sb_drained", sb.size(), 0);
        bus.meas_en = 1'b0;
        tick();
        tick();
        bus.exp_ratio = RATIO_WD'(exp);
        model_restart();
        bus.meas_en = 1'b1;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ratio"},     bus.ratio,     0);
        check({tag, "_ratio_vld"}, bus.ratio_vld, 0);
        check({tag, "_high_cnt"},  bus.high_cnt,  0);
        check({tag, "_locked"},    bus.locked,    0);
        check({tag, "_ratio_err"}, bus.ratio_err, 0);
        check({tag, "_mismatch"},  bus.mismatch,  0);
        check({tag, "_timeout"},   bus.timeout,   0);
    endtask

    // Monitor: every sample is matched against the oldest expectation; ratio_err one cycle later
    always @(negedge clk) begin
        if (pend_err) begin
            check("ratio_err_after_vld", bus.ratio_err, err_exp);
            pend_err = 1'b0;
        end
        if (!rst && bus.ratio_vld) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_vld: got ratio %0d, required no sample (cycle %0d)", bus.ratio, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ratio",    bus.ratio,    mon_e.ratio);
                check("high_cnt", bus.high_cnt, mon_e.high);
                check("locked",   bus.locked,   mon_e.locked);
                check("mismatch", bus.mismatch, mon_e.mismatch);
                check("timeout",  bus.timeout,  mon_e.timeout);
                err_exp  = mon_e.locked && (mon_e.ratio != int'(bus.exp_ratio));
                pend_err = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned fall_c;
        int unsigned to_c;
        bit          seen;
        bit          prev_locked;
        int unsigned exp;
        int unsigned r;
        int unsigned hi;

        rst           = 1'b1;
        bus.meas_en   = 1'b0;
        bus.div_clk   = 1'b0;
        bus.exp_ratio = '0;
        model_restart();
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Ratio 8, even duty, expected ratio matches
        restart(8);
        run_periods(8, 4, 8);
        @(negedge clk);
        check("lock8_locked", bus.locked, 1);

        // Odd ratio 5 with 3-cycle high phase
        restart(5);
        run_periods(5, 3, 7);

        // Locked at 8, divider switched to 6: mismatch then relock
        restart(8);
        run_periods(8, 4, 6);
        run_periods(6, 3, 6);
        @(negedge clk);
        check("relock6_locked",   bus.locked,   1);
        check("relock6_mismatch", bus.mismatch, 1);

        // Stall while locked: timeout fires once the fall has been quiet for 255 cycles
        restart(8);
        run_periods(8, 4, 6);
        fall_c      = last_fall;
        seen        = 1'b0;
        to_c        = 0;
        prev_locked = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.timeout) begin
                seen = 1'b1;
                to_c = cyc;
            end else begin
                prev_locked = bus.locked;
            end
        end
        check("timeout_seen",          seen, 1);
        // fall visible after SYNC_STAGES, registered into the edge flop, then 255 quiet cycles
        check("timeout_cycle",         to_c, fall_c + SYNC_STAGES + 1 + 255);
        check("locked_before_timeout", prev_locked, 1);
        check("timeout_unlocks",       bus.locked, 0);
        model_timeout();
        tick();
        run_periods(8, 4, 6);

        // Ratio error against a wrong expected ratio, then corrected
        restart(10);
        run_periods(8, 4, 6);
        repeat (2) tick();
        @(negedge clk);
        check("err_wrong_exp", bus.ratio_err, 1);
        tick();
        bus.exp_ratio = RATIO_WD'(8);
        @(negedge clk);
        check("err_same_cycle", bus.ratio_err, 1);
        @(negedge clk);
        check("err_cleared", bus.ratio_err, 0);

        // Reset pulsed in MEASURE, then a fresh measurement
        restart(8);
        run_periods(8, 4, 3);
        check("pre_reset_ratio", bus.ratio, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        check("rst_mid_sb_empty", sb.size(), 0);
        model_restart();
        tick();
        run_periods(8, 4, 7);

        // Randomized ratios and duty cycles
        for (int round = 0; round < 3; round++) begin
            exp = $urandom_range(2, 40);
            restart(exp);
            for (int s = 0; s < 20; s++) begin
                r  = ($urandom_range(0, 1) == 1) ? exp : $urandom_range(2, 40);
                hi = $urandom_range(1, r - 1);
                run_periods(r, hi, $urandom_range(1, 8));
            end
        end

        repeat (6) tick();
        check("final_sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

Measures the division ratio of a divided clock in the reference-clock domain: it counts `i_ref_clk` cycles between successive edges of `i_div_clk` and reports the period in reference cycles. It locks once the period is stable and flags deviation from an expected ratio or a stalled clock. It sits next to each clock divider instance as the receiving-side checker, so configuration and test logic can confirm the programmed ratio actually took effect.

## Interface
- `RATIO_WD`, 8, width of the ratio and all counters.
- `LOCK_CNT`, 4, consecutive equal periods required to lock (range 2..15).
- `SYNC_STAGES`, 2, synchronizer depth on `i_div_clk` (≥2).

- `i_ref_clk` in 1: reference clock; the only clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_meas_en` in 1: measurement enable; low forces IDLE.
- `i_div_clk` in 1: divided clock under measurement, treated as asynchronous data.
- `i_exp_ratio` in RATIO_WD: expected ratio, quasi-static.
- `o_ratio` out RATIO_WD: last measured period in `i_ref_clk` cycles.
- `o_ratio_vld` out 1: one-cycle pulse per new `o_ratio`.
- `o_high_cnt` out RATIO_WD: high-phase length of the last period.
- `o_locked` out 1: period stable for LOCK_CNT samples.
- `o_ratio_err` out 1: locked and `o_ratio != i_exp_ratio`.
- `o_mismatch` out 1: sticky; lost lock due to a changed period.
- `o_timeout` out 1: sticky; no edge for 2^RATIO_WD−1 cycles.

## Operation
- `i_div_clk` passes through a SYNC_STAGES flop chain, then one more flop for edge detection.
  - Rise detect (rd) = sync & ~prev.
  - Fall detect (fd) = ~sync & prev.
- Period counter `p`:
  - On rd: `p <= 1`.
  - Otherwise `p <= p+1`, saturating at all-ones.
  - The measured period is the value of `p` in the rd cycle.
- High counter `h`: `h <= 1` on rd, else `h+1` (saturating). Its value is captured on fd.
- Edge-gap counter: cleared on rd or fd, else increments. Reaching 2^RATIO_WD−1 is a timeout.
- FSM states: IDLE, WAIT_EDGE, MEASURE, LOCKED.
  - IDLE: counters cleared, `consec=0`. If `i_meas_en` → WAIT_EDGE.
  - WAIT_EDGE: on rd → MEASURE, `p` restarts; no sample is taken (first partial period discarded).
  - MEASURE, on each rd:
    - Sample S to `o_ratio` and pulse `o_ratio_vld`.
    - If S equals the previous sample, `consec++`; else `consec=1`.
    - When `consec` reaches LOCK_CNT → LOCKED.
  - LOCKED, on each rd:
    - Sample S, update `o_ratio`, pulse `o_ratio_vld`.
    - If S differs from the locked value: set `o_mismatch`, `consec=1`, → MEASURE.
  - Timeout in any non-IDLE state: set `o_timeout`, clear `consec`, → WAIT_EDGE.
  - `i_meas_en` low in any state → IDLE. Sticky flags and `o_ratio` are cleared in that transition.
- `o_locked` = (state == LOCKED), registered.
- `o_ratio_err` is registered from `o_locked && o_ratio != i_exp_ratio`.
- Ratios 0 and 1 (divider bypass, `i_div_clk` = `i_ref_clk`) produce no detectable edges → `o_timeout`, by design.
- Simultaneous timeout and rd: rd wins (the counter is cleared that cycle).

## Timing
- All outputs are 0 after reset; the FSM is in IDLE.
- Edge on `i_div_clk` to rd: SYNC_STAGES+1 cycles.
- rd to `o_ratio`/`o_ratio_vld`: 1 cycle, registered.
- `o_locked` rises 1 cycle after rd number LOCK_CNT+1, counting from the first rd seen in WAIT_EDGE, for a constant ratio.
- `o_mismatch` and `o_locked` falling change in the same cycle as the offending `o_ratio_vld`.
- `i_rst` mid-operation: the next cycle is in IDLE with all outputs 0, regardless of state.

## Configuration
- `CLK_RATIO_METER_DUTY_EN`:
  - Defined: the high counter is built and `o_high_cnt` reports the captured high phase, updated with `o_ratio_vld`.
  - Undefined: there is no high counter and `o_high_cnt` is tied to 0.
  - Period, lock, error and timeout behaviour are identical in both builds.

## Test plan
- Ratio 8, `i_meas_en`=1, LOCK_CNT=4:
  - `o_ratio`=8 on every `o_ratio_vld`.
  - `o_locked`=1 after the 5th rise.
  - `o_high_cnt`=4, `o_ratio_err`=0 with `i_exp_ratio`=8.
- Odd ratio 5: `o_ratio`=5, `o_high_cnt`=3 (low 2), lock achieved.
- Locked at 8, divider switched to 6:
  - First differing sample gives `o_ratio`=6, `o_mismatch`=1, `o_locked`=0.
  - Relock after 4 equal samples; `o_mismatch` stays 1.
- `i_div_clk` held at 0 while locked: `o_timeout`=1 and `o_locked`=0 exactly 255 cycles after the last edge (RATIO_WD=8).
- Locked at 8 with `i_exp_ratio`=10: `o_ratio_err`=1. Then set `i_exp_ratio`=8: `o_ratio_err`=0 the next cycle.
- `i_rst` pulsed in MEASURE: all outputs 0 the next cycle. Remeasure from WAIT_EDGE gives the correct lock timing.
